// File: rtl/sat_accumulator.sv
// Saturating signed accumulator: sums num_terms operands accepted over a
// valid/ready handshake, clamping to the W-bit signed range and flagging overflow.
module sat_accumulator #(
   parameter int W  = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] num_terms,
   input  logic [W-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  acc_out,
   output logic          out_valid,
   output logic          busy,
   output logic          ovf,
   output logic [CW-1:0] remaining,
   output logic [1:0]    state_dbg
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [1:0]   state;
   logic         hs;
   logic [W-1:0] raw_sum;
   logic         add_ovf;
   logic [W-1:0] sat_sum;

   // Handshake: an operand transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready depends only on state, never on in_valid.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign hs        = in_valid && in_ready;

   always_comb begin
      raw_sum = acc_out + in_data;
      add_ovf = (acc_out[W-1] == in_data[W-1]) && (raw_sum[W-1] != acc_out[W-1]);
      sat_sum = raw_sum;
      if (add_ovf) sat_sum = acc_out[W-1] ? SAT_MIN : SAT_MAX;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_out   <= '0;
         ovf       <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc_out   <= '0;
                  ovf       <= 1'b0;
                  remaining <= num_terms;
                  state     <= (num_terms == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (hs) begin
                  acc_out   <= sat_sum;
                  remaining <= remaining - 1'b1;
                  if (add_ovf) ovf <= 1'b1;
                  if (remaining == CW'(1)) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: linear stimulus with hand-computed
// expectations checked by immediate assertions one cycle at a time.
module tb_sat_accumulator;

   localparam int W  = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] num_terms;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  acc_out;
   logic          out_valid;
   logic          busy;
   logic          ovf;
   logic [CW-1:0] remaining;
   logic [1:0]    state_dbg;

   int tests  = 0;
   int failed = 0;

   // in_valid pattern for the stalled run and its expected trace
   logic        pat_v   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [15:0] pat_d   [7] = '{16'd1, 16'd1000, 16'd1000, 16'd2, 16'd3, 16'd1000, 16'd4};
   logic [15:0] pat_acc [7] = '{16'd1, 16'd1, 16'd1, 16'd3, 16'd6, 16'd6, 16'd10};
   logic [7:0]  pat_rem [7] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0};
   logic        pat_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   sat_accumulator #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_terms (num_terms),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .busy      (busy),
      .ovf       (ovf),
      .remaining (remaining),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // advance one rising edge; inputs change and outputs are sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e_acc, input logic [7:0] e_rem,
                          input logic e_ovf, input logic e_ov, input logic e_rdy, input logic e_busy);
      chk({tag, ".acc"},   32'(acc_out),   32'(e_acc));
      chk({tag, ".rem"},   32'(remaining), 32'(e_rem));
      chk({tag, ".ovf"},   32'(ovf),       32'(e_ovf));
      chk({tag, ".ov"},    32'(out_valid), 32'(e_ov));
      chk({tag, ".rdy"},   32'(in_ready),  32'(e_rdy));
      chk({tag, ".busy"},  32'(busy),      32'(e_busy));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_terms = '0; in_data = '0; in_valid = 1'b0;
      step(); step();
      chk_all("reset", 16'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(); step();
      chk_all("post_reset_idle", 16'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // basic three-term sum
      start = 1'b1; num_terms = 8'd3;
      step();
      chk_all("b_start", 16'h0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      start = 1'b0; in_valid = 1'b1; in_data = 16'd100;
      step(); chk_all("b_t1", 16'd100, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'hFFE2;  // -30
      step(); chk_all("b_t2", 16'd70, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'd7;
      step(); chk_all("b_done", 16'd77, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      step(); chk_all("b_idle", 16'd77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("b_hold", 16'd77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // positive saturation
      start = 1'b1; num_terms = 8'd2;
      step(); start = 1'b0;
      chk_all("p_start", 16'h0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b1; in_data = 16'h7000;
      step(); chk_all("p_t1", 16'h7000, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'h2000;
      step(); chk_all("p_done", 16'h7FFF, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      step(); chk_all("p_idle", 16'h7FFF, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // negative saturation; start clears the sticky flag
      start = 1'b1; num_terms = 8'd2;
      step(); start = 1'b0;
      chk_all("n_start", 16'h0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b1; in_data = 16'h8001;
      step(); chk_all("n_t1", 16'h8001, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'hFFF0;
      step(); chk_all("n_done", 16'h8000, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      step(); chk_all("n_idle", 16'h8000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // stalled input: only valid cycles count
      start = 1'b1; num_terms = 8'd4;
      step(); start = 1'b0;
      chk_all("s_start", 16'h0, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         in_valid = pat_v[i]; in_data = pat_d[i];
         step();
         chk_all($sformatf("s_c%0d", i), pat_acc[i], pat_rem[i], 1'b0, pat_ov[i],
                 !pat_ov[i], 1'b1);
      end
      in_valid = 1'b1; in_data = 16'd50;  // ignored in IDLE
      step(); chk_all("s_idle", 16'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;

      // zero terms goes straight to DONE
      start = 1'b1; num_terms = 8'd0;
      step(); start = 1'b0;
      chk_all("z_done", 16'h0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_all("z_idle", 16'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset aborts after two of five handshakes
      start = 1'b1; num_terms = 8'd5;
      step(); start = 1'b0;
      in_valid = 1'b1; in_data = 16'd10;
      step(); chk_all("r_t1", 16'd10, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'd20;
      step(); chk_all("r_t2", 16'd30, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b0; start = 1'b1; in_data = 16'd40;
      step(); chk_all("r_abort", 16'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
      step(); chk_all("r_no_auto", 16'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      start = 1'b1; num_terms = 8'd1;
      step(); start = 1'b0;
      chk_all("r_restart", 16'h0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b1; in_data = 16'd5;
      step(); chk_all("r_done", 16'd5, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      step(); chk_all("r_idle", 16'd5, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start ignored in ACCUM and DONE; num_terms changes have no effect
      start = 1'b1; num_terms = 8'd3;
      step(); start = 1'b0;
      in_valid = 1'b1; in_data = 16'h7FFF;
      step(); chk_all("i_t1", 16'h7FFF, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      in_data = 16'd1;
      step(); chk_all("i_t2", 16'h7FFF, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b0; start = 1'b1; num_terms = 8'd9;
      step(); chk_all("i_accum_start", 16'h7FFF, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      start = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
      step(); chk_all("i_done", 16'h7FFE, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      start = 1'b1; num_terms = 8'd7; in_data = 16'd100;
      step(); chk_all("i_done_start", 16'h7FFE, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b0; in_valid = 1'b0;
      step(); chk_all("i_idle", 16'h7FFE, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
